// File: rtl/sim_end_monitor.sv
// -----------------------------------------------------------------------------
// sim_end_monitor
//
// Purpose:
//   End-of-test monitor that sits on the data-memory store port of a core.
//   Every store the core issues is observed. A sentinel store (full-width
//   write of END_MAGIC) ends the test: the monitor waits a fixed drain window
//   and then raises a sticky done. The monitor also keeps a saturating cycle
//   count, a store count, and a rolling XOR/rotate signature of the masked
//   store data. A watchdog raises a sticky timeout if no sentinel arrives in
//   time. Every output is a register.
//
// Ports:
//   clk         in   core clock
//   rst_n       in   asynchronous active-low reset, clears all state
//   st_valid    in   store issued this cycle
//   st_addr     in   store byte address                    [ADDR_WIDTH]
//   st_data     in   store data, lane-aligned              [DATA_WIDTH]
//   st_wstrb    in   byte-lane write enables               [DATA_WIDTH/8]
//   done        out  sticky, drain window complete after the sentinel
//   timeout     out  sticky, watchdog expired before any sentinel
//   cycle_count out  cycles spent in RUN/DRAIN since reset  [CNT_WIDTH]
//   store_count out  accepted stores                       [CNT_WIDTH]
//   signature   out  rolling store signature               [DATA_WIDTH]
//   end_cycle   out  cycle_count on the sentinel cycle     [CNT_WIDTH]
//   end_addr    out  address of the sentinel store         [ADDR_WIDTH]
// -----------------------------------------------------------------------------
module sim_end_monitor #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [DATA_WIDTH-1:0] END_MAGIC      = DATA_WIDTH'(32'hDEADBEEF),
    parameter int                    DRAIN_CYCLES   = 5,
    parameter int                    TIMEOUT_CYCLES = 100000,
    parameter int                    CNT_WIDTH      = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    st_valid,
    input  logic [ADDR_WIDTH-1:0]   st_addr,
    input  logic [DATA_WIDTH-1:0]   st_data,
    input  logic [DATA_WIDTH/8-1:0] st_wstrb,
    output logic                    done,
    output logic                    timeout,
    output logic [CNT_WIDTH-1:0]    cycle_count,
    output logic [CNT_WIDTH-1:0]    store_count,
    output logic [DATA_WIDTH-1:0]   signature,
    output logic [CNT_WIDTH-1:0]    end_cycle,
    output logic [ADDR_WIDTH-1:0]   end_addr
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_DRAIN   = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;
    localparam logic [1:0] ST_TIMEOUT = 2'd3;

    localparam logic [CNT_WIDTH-1:0]  CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [STRB_WIDTH-1:0] STRB_ALL = {STRB_WIDTH{1'b1}};

    // A zero-length drain window skips DRAIN altogether.
    localparam bit DRAIN_SKIP = (DRAIN_CYCLES == 0);
    localparam logic [CNT_WIDTH-1:0] DRAIN_LOAD =
        (DRAIN_CYCLES > 0) ? CNT_WIDTH'(DRAIN_CYCLES - 1) : CNT_ZERO;

    localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_WIDTH-1:0] WD_LIMIT =
        (TIMEOUT_CYCLES > 0) ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : CNT_ZERO;

    // Zero every byte lane whose write enable is clear.
    function automatic logic [DATA_WIDTH-1:0] mask_lanes(
        input logic [DATA_WIDTH-1:0] data,
        input logic [STRB_WIDTH-1:0] strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < STRB_WIDTH; i++) begin
            res[i*8 +: 8] = strb[i] ? data[i*8 +: 8] : 8'h00;
        end
        return res;
    endfunction

    // Rotate left by one bit.
    function automatic logic [DATA_WIDTH-1:0] rotl1(input logic [DATA_WIDTH-1:0] x);
        return {x[DATA_WIDTH-2:0], x[DATA_WIDTH-1]};
    endfunction

    logic [1:0]            state_q,     state_d;
    logic [CNT_WIDTH-1:0]  drain_q,     drain_d;
    logic [CNT_WIDTH-1:0]  cycle_q,     cycle_d;
    logic [CNT_WIDTH-1:0]  store_q,     store_d;
    logic [DATA_WIDTH-1:0] sig_q,       sig_d;
    logic [CNT_WIDTH-1:0]  end_cycle_q, end_cycle_d;
    logic [ADDR_WIDTH-1:0] end_addr_q,  end_addr_d;
    logic                  done_q,      done_d;
    logic                  timeout_q,   timeout_d;

    logic accept_s;
    logic sentinel_s;
    logic wd_hit_s;

    // Store qualification, sentinel detection and watchdog hit.
    always_comb begin
        accept_s   = 1'b0;
        sentinel_s = 1'b0;
        wd_hit_s   = 1'b0;
        if ((state_q == ST_RUN) || (state_q == ST_DRAIN)) begin
            accept_s = st_valid;
        end else begin
            accept_s = 1'b0;
        end
        // Only the first sentinel (in RUN) counts; later ones are plain data.
        if ((state_q == ST_RUN) && st_valid && (st_wstrb == STRB_ALL) &&
            (st_data == END_MAGIC)) begin
            sentinel_s = 1'b1;
        end else begin
            sentinel_s = 1'b0;
        end
        // A sentinel in the watchdog's final cycle wins over the timeout.
        if (WD_EN && (state_q == ST_RUN) && (cycle_q == WD_LIMIT) && !sentinel_s) begin
            wd_hit_s = 1'b1;
        end else begin
            wd_hit_s = 1'b0;
        end
    end

    // Next-state logic for the FSM, counters and status registers.
    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        cycle_d     = cycle_q;
        store_d     = store_q;
        sig_d       = sig_q;
        end_cycle_d = end_cycle_q;
        end_addr_d  = end_addr_q;

        case (state_q)
            ST_RUN: begin
                if (sentinel_s) begin
                    end_cycle_d = cycle_q;
                    end_addr_d  = st_addr;
                    drain_d     = DRAIN_LOAD;
                    if (DRAIN_SKIP) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else if (wd_hit_s) begin
                    state_d = ST_TIMEOUT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (drain_q == CNT_ZERO) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q - CNT_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            ST_TIMEOUT: begin
                state_d = ST_TIMEOUT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (accept_s) begin
            store_d = store_q + CNT_ONE;
            if (!sentinel_s) begin
                sig_d = rotl1(sig_q) ^ mask_lanes(st_data, st_wstrb);
            end else begin
                sig_d = sig_q;
            end
        end else begin
            store_d = store_q;
        end

        // The edge that enters a terminal state does not advance the count,
        // so cycle_count freezes at the value seen in the last live cycle.
        if (((state_d == ST_RUN) || (state_d == ST_DRAIN)) && (cycle_q != CNT_MAX)) begin
            cycle_d = cycle_q + CNT_ONE;
        end else begin
            cycle_d = cycle_q;
        end

        // done follows DONE by one edge, giving DRAIN_CYCLES+1 edges after the
        // sentinel edge; timeout rises on the watchdog edge itself.
        done_d    = (state_q == ST_DONE);
        timeout_d = (state_d == ST_TIMEOUT);
    end

    // State and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            drain_q     <= CNT_ZERO;
            cycle_q     <= CNT_ZERO;
            store_q     <= CNT_ZERO;
            sig_q       <= {DATA_WIDTH{1'b0}};
            end_cycle_q <= CNT_ZERO;
            end_addr_q  <= {ADDR_WIDTH{1'b0}};
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            cycle_q     <= cycle_d;
            store_q     <= store_d;
            sig_q       <= sig_d;
            end_cycle_q <= end_cycle_d;
            end_addr_q  <= end_addr_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
        end
    end

    assign done        = done_q;
    assign timeout     = timeout_q;
    assign cycle_count = cycle_q;
    assign store_count = store_q;
    assign signature   = sig_q;
    assign end_cycle   = end_cycle_q;
    assign end_addr    = end_addr_q;

endmodule

// File: tb/tb_sim_end_monitor.sv
// -----------------------------------------------------------------------------
// tb_sim_end_monitor
//
// Two monitors share one store stream: instance 0 uses DRAIN_CYCLES=5 and
// TIMEOUT_CYCLES=50, instance 1 uses DRAIN_CYCLES=0 with the watchdog off.
// After every clock edge a reference model, written in terms of edge numbers
// since reset release, pushes the expected outputs of each instance into a
// queue; a monitor process pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_sim_end_monitor;

    localparam logic [31:0] MAGIC = 32'hDEADBEEF;

    typedef struct packed {
        int          inst;
        logic        done;
        logic        to;
        logic [31:0] cc;
        logic [31:0] sc;
        logic [31:0] sig;
        logic [31:0] ec;
        logic [31:0] ea;
    } obs_t;

    logic        clk;
    logic        rst_n;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_wstrb;

    logic        done_w [2];
    logic        to_w   [2];
    logic [31:0] cc_w   [2];
    logic [31:0] sc_w   [2];
    logic [31:0] sig_w  [2];
    logic [31:0] ec_w   [2];
    logic [31:0] ea_w   [2];

    int checks   = 0;
    int failures = 0;

    obs_t sb[$];

    sim_end_monitor #(.DRAIN_CYCLES(5), .TIMEOUT_CYCLES(50)) u_a (
        .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_addr(st_addr),
        .st_data(st_data), .st_wstrb(st_wstrb), .done(done_w[0]), .timeout(to_w[0]),
        .cycle_count(cc_w[0]), .store_count(sc_w[0]), .signature(sig_w[0]),
        .end_cycle(ec_w[0]), .end_addr(ea_w[0])
    );

    sim_end_monitor #(.DRAIN_CYCLES(0), .TIMEOUT_CYCLES(0)) u_b (
        .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_addr(st_addr),
        .st_data(st_data), .st_wstrb(st_wstrb), .done(done_w[1]), .timeout(to_w[1]),
        .cycle_count(cc_w[1]), .store_count(sc_w[1]), .signature(sig_w[1]),
        .end_cycle(ec_w[1]), .end_addr(ea_w[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    int          dp [2] = '{5, 0};
    int          tp [2] = '{50, 0};
    int          k;
    bit          m_ended [2];
    bit          m_to    [2];
    int          m_s     [2];
    logic [31:0] m_cc    [2];
    logic [31:0] m_sc    [2];
    logic [31:0] m_sig   [2];
    logic [31:0] m_ec    [2];
    logic [31:0] m_ea    [2];

    function automatic logic [31:0] masked(input logic [31:0] d, input logic [3:0] w);
        logic [31:0] r;
        r = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if (w[i]) r = r | (d & (32'hFF << (8 * i)));
        end
        return r;
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] x);
        return (x << 1) | (x >> 31);
    endfunction

    task automatic model_reset();
        k = 0;
        for (int i = 0; i < 2; i++) begin
            m_ended[i] = 1'b0; m_to[i] = 1'b0; m_s[i] = 0;
            m_cc[i] = 32'd0; m_sc[i] = 32'd0; m_sig[i] = 32'd0;
            m_ec[i] = 32'd0; m_ea[i] = 32'd0;
        end
    endtask

    // Edge k of the run: the sentinel edge is s; stores are accepted up to and
    // including edge s+D; done is visible from edge s+D+1 onward.
    task automatic model_edge(input logic v, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] w);
        bit accepting, sentinel, tmo, term;
        k++;
        for (int i = 0; i < 2; i++) begin
            accepting = !m_to[i] && (!m_ended[i] || (k <= m_s[i] + dp[i]));
            sentinel  = accepting && !m_ended[i] && v && (w == 4'hF) && (d == MAGIC);
            tmo       = accepting && !m_ended[i] && (tp[i] != 0) &&
                        (m_cc[i] == 32'(tp[i] - 1)) && !sentinel;
            if (accepting && v) begin
                m_sc[i] = m_sc[i] + 32'd1;
                if (!sentinel) m_sig[i] = rotl(m_sig[i]) ^ masked(d, w);
            end
            if (sentinel) begin
                m_ended[i] = 1'b1; m_s[i] = k; m_ec[i] = m_cc[i]; m_ea[i] = a;
            end
            term = m_to[i] || tmo || (m_ended[i] && (k >= m_s[i] + dp[i]));
            if (!term && (m_cc[i] != 32'hFFFFFFFF)) m_cc[i] = m_cc[i] + 32'd1;
            if (tmo) m_to[i] = 1'b1;
        end
    endtask

    task automatic push_expect();
        obs_t e;
        for (int i = 0; i < 2; i++) begin
            e.inst = i;
            e.done = m_ended[i] && (k >= m_s[i] + dp[i] + 1);
            e.to   = m_to[i];
            e.cc   = m_cc[i];
            e.sc   = m_sc[i];
            e.sig  = m_sig[i];
            e.ec   = m_ec[i];
            e.ea   = m_ea[i];
            sb.push_back(e);
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input int inst,
                       input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d got=%08h exp=%08h", name, inst, got, exp);
        end
    endtask

    initial begin : monitor
        obs_t e;
        int   i;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                i = e.inst;
                chk("done",        i, 32'(done_w[i]), 32'(e.done));
                chk("timeout",     i, 32'(to_w[i]),   32'(e.to));
                chk("cycle_count", i, cc_w[i],  e.cc);
                chk("store_count", i, sc_w[i],  e.sc);
                chk("signature",   i, sig_w[i], e.sig);
                chk("end_cycle",   i, ec_w[i],  e.ec);
                chk("end_addr",    i, ea_w[i],  e.ea);
            end
        end
    end

    // ---------------- stimulus ----------------
    // Inputs change 1 time unit after the falling edge, away from sampling.
    task automatic step(input logic v, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] w);
        #1;
        st_valid = v; st_addr = a; st_data = d; st_wstrb = w;
        @(posedge clk);
        model_edge(v, a, d, w);
        push_expect();
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, $urandom, $urandom, 4'($urandom));
    endtask

    task automatic rand_store(input bit allow_sent);
        logic        v;
        logic [31:0] a, d;
        logic [3:0]  w;
        v = ($urandom_range(0, 3) != 0);
        a = $urandom & 32'hFFFF_FFFC;
        d = $urandom;
        w = 4'($urandom);
        if (d == MAGIC) d = d ^ 32'd1;
        if (allow_sent && ($urandom_range(0, 24) == 0)) begin
            v = 1'b1; d = MAGIC; w = 4'hF;
        end
        step(v, a, d, w);
    endtask

    task automatic do_reset(input int n);
        #1;
        rst_n = 1'b0;
        st_valid = 1'b0;
        model_reset();
        for (int j = 0; j < n; j++) begin
            @(posedge clk);
            push_expect();
            @(negedge clk);
        end
        #1;
        rst_n = 1'b1;
    endtask

    initial begin : stim
        rst_n = 1'b0; st_valid = 1'b0; st_addr = 32'd0; st_data = 32'd0; st_wstrb = 4'd0;
        model_reset();
        @(negedge clk);
        do_reset(3);

        // Idle after reset, then two stores and a sentinel at cycle 20.
        repeat (10) idle();
        chk("idle_cycle_count", 0, cc_w[0], 32'd10);
        chk("idle_store_count", 0, sc_w[0], 32'd0);
        chk("idle_signature",   0, sig_w[0], 32'd0);
        step(1'b1, 32'h0, 32'h0000_0001, 4'hF);
        step(1'b1, 32'h4, 32'h0000_0002, 4'hF);
        repeat (8) idle();
        step(1'b1, 32'h100, MAGIC, 4'hF);
        chk("sent_signature",   0, sig_w[0], 32'd0);
        chk("sent_store_count", 0, sc_w[0], 32'd3);
        chk("sent_end_cycle",   0, ec_w[0], 32'd20);
        chk("sent_end_addr",    0, ea_w[0], 32'h100);
        chk("drain0_not_yet",   1, 32'(done_w[1]), 32'd0);
        idle();
        chk("drain0_done_next", 1, 32'(done_w[1]), 32'd1);
        chk("drain5_not_yet",   0, 32'(done_w[0]), 32'd0);
        step(1'b1, 32'h200, MAGIC, 4'hF);
        rand_store(1'b0);
        rand_store(1'b0);
        rand_store(1'b0);
        chk("drain5_edge5", 0, 32'(done_w[0]), 32'd0);
        idle();
        chk("drain5_edge6", 0, 32'(done_w[0]), 32'd1);
        chk("drain5_no_to", 0, 32'(to_w[0]), 32'd0);
        repeat (4) rand_store(1'b1);

        // Partial strobes; short-strobe sentinel not detected; watchdog.
        do_reset(2);
        step(1'b1, 32'h40, 32'h1122_3344, 4'b0101);
        chk("mask_signature", 0, sig_w[0], 32'h0022_0044);
        step(1'b1, 32'h44, MAGIC, 4'h7);
        idle();
        chk("wstrb7_not_sent", 1, 32'(done_w[1]), 32'd0);
        repeat (57) rand_store(1'b0);
        chk("wd_timeout", 0, 32'(to_w[0]), 32'd1);
        chk("wd_cc_frozen", 0, cc_w[0], 32'd49);
        step(1'b1, 32'h300, MAGIC, 4'hF);
        repeat (3) idle();
        chk("wd_sent_ignored", 0, 32'(done_w[0]), 32'd0);
        chk("wd_still_to", 0, 32'(to_w[0]), 32'd1);

        // Sentinel in the watchdog's last cycle wins.
        do_reset(2);
        repeat (49) idle();
        step(1'b1, 32'h500, MAGIC, 4'hF);
        repeat (7) idle();
        chk("race_done", 0, 32'(done_w[0]), 32'd1);
        chk("race_no_to", 0, 32'(to_w[0]), 32'd0);

        // Reset in the middle of the drain window.
        do_reset(2);
        repeat (2) idle();
        step(1'b1, 32'h600, MAGIC, 4'hF);
        repeat (2) idle();
        do_reset(2);
        repeat (20) idle();
        chk("abort_no_done", 0, 32'(done_w[0]), 32'd0);
        chk("abort_end_cycle", 0, ec_w[0], 32'd0);
        chk("abort_cc", 0, cc_w[0], 32'd20);

        // Randomized runs with occasional sentinels.
        repeat (6) begin
            do_reset(2);
            repeat (80) rand_store(1'b1);
        end

        idle();
        @(negedge clk);
        chk("scoreboard_empty", 0, 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
